bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one WIDTH-bit internal bus between N_REQ requesters.

---
 rtl/bus_arb_pkg.sv | 30 +++
 rtl/gen_mux.sv | 27 ++
 rtl/rr_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module   : bus_arb_pkg
// Brief    : Shared types, default sizes and helpers for the bus arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gen_mux.sv
// ============================================================================
// Module   : gen_mux
// Brief    : Generic LENGTH-input, WIDTH-bit binary-select data multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_mux #(
    parameter int LENGTH = 4,
    parameter int WIDTH  = 16,
    parameter int SEL_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic [LENGTH*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (sel == SEL_W'(i)) dout = din[i*WIDTH +: WIDTH];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; scans upward from last_owner+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_owner,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    int w_idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_idx  = 0;
        // The previous owner is visited last, giving it the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(last_owner) + k) % N_REQ;
            if (!any && req[w_idx]) begin
                winner = w_idx[SEL_W-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin owner arbitration and registered shared-bus driver.
//            Define BUS_ARB_TIMEOUT_EN to enable MAX_HOLD ownership preemption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = 8,
    localparam int SEL_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       grant,
    output logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       bus_data,
    output logic                   bus_valid,
    output logic                   busy,
    output logic                   preempt
);

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last_owner;
    logic [WIDTH-1:0] r_bus_data;
    logic             r_bus_valid;
    logic [SEL_W-1:0] w_winner;
    logic             w_any;
    logic [WIDTH-1:0] w_mux_out;
    logic             w_owner_req;
    logic             w_timeout;
    logic [N_REQ-1:0] w_grant;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_rr_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .winner     (w_winner),
        .any        (w_any)
    );

    gen_mux #(.LENGTH(N_REQ), .WIDTH(WIDTH), .SEL_W(SEL_W)) u_mux (
        .din  (data),
        .sel  (r_sel),
        .dout (w_mux_out)
    );

    assign w_owner_req = req[r_sel];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);
    logic [c_hold_w-1:0] r_hold;

    // Saturates so a long-running sole owner is released as soon as a rival appears.
    always_ff @(posedge clk) begin
        if (rst || r_state != GRANT) begin
            r_hold <= '0;
        end else if (r_hold < c_hold_w'(MAX_HOLD - 1)) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign w_timeout = (r_state == GRANT) && w_owner_req &&
                       (r_hold == c_hold_w'(MAX_HOLD - 1)) && (|(req & ~w_grant));
`else
    logic w_unused_hold;
    assign w_unused_hold = (MAX_HOLD > 0);
    assign w_timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, RELEASE: w_next_state = w_any ? GRANT : IDLE;
            GRANT:         if (!w_owner_req || w_timeout) w_next_state = RELEASE;
            default:       w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_grant = '0;
        if (r_state == GRANT) w_grant[r_sel] = 1'b1;
        grant   = w_grant;
        busy    = (r_state == GRANT);
        preempt = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= '0;
            r_last_owner <= SEL_W'(N_REQ - 1);
            r_bus_data   <= '0;
            r_bus_valid  <= 1'b0;
        end else begin
            if (r_state != GRANT && w_any) r_sel <= w_winner;
            if (r_state == GRANT) begin
                r_bus_data <= w_mux_out;
                if (w_next_state == RELEASE)
                    r_last_owner <= SEL_W'(onehot_to_idx(32'(w_grant)));
            end
            r_bus_valid <= (r_state == GRANT) && (w_next_state == GRANT);
        end
    end

    generate
        if (N_REQ == 1) begin : g_single
            assign sel = '0;
        end else begin : g_multi
            assign sel = r_sel;
        end
    endgenerate

    assign bus_data  = r_bus_data;
    assign bus_valid = r_bus_valid;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter (N_REQ=4, WIDTH=16, MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXH = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [1:0]     sel;
    logic [W-1:0]   bus_data;
    logic           bus_valid;
    logic           busy;
    logic           preempt;

    always #5 clk = ~clk;

    bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .sel       (sel),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .busy      (busy),
        .preempt   (preempt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 = nobody), last owner, held-cycle count.
    int         m_owner;
    int         m_last;
    int         m_sel;
    int         m_cnt;
    logic       m_bv;
    logic [W-1:0] m_bd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_pre(input logic [N-1:0] r);
        logic [N-1:0] others;
        if (!TMO || m_owner < 0) return 1'b0;
        others = r & ~(N'(1) << m_owner);
        return r[m_owner] && (m_cnt == MAXH - 1) && (others != 0);
    endfunction

    task automatic model_step(input logic r_rst, input logic [N-1:0] r_req, input logic [N*W-1:0] r_data);
        logic pre;
        pre = m_pre(r_req);
        if (r_rst) begin
            m_owner = -1; m_last = N - 1; m_sel = 0; m_cnt = 0; m_bv = 1'b0; m_bd = '0;
        end else if (m_owner >= 0) begin
            m_bd = r_data[m_owner*W +: W];
            if (!r_req[m_owner] || pre) begin
                m_last = m_owner; m_owner = -1; m_bv = 1'b0;
            end else begin
                m_bv = 1'b1;
                if (m_cnt < MAXH - 1) m_cnt++;
            end
        end else begin
            m_bv = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && r_req[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N; m_sel = m_owner; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic r_rst, input logic [N-1:0] r_req, input logic [N*W-1:0] r_data);
        @(negedge clk);
        rst = r_rst; req = r_req; data = r_data;
        @(posedge clk);
        model_step(r_rst, r_req, r_data);
        #1;
        chk("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_bus_valid", 32'(bus_valid), 32'(m_bv));
        chk("model_bus_data", 32'(bus_data), 32'(m_bd));
        chk("model_busy", 32'(busy), 32'(m_owner >= 0));
        chk("model_preempt", 32'(preempt), 32'(m_pre(req)));
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic [1:0]   sel;
        logic         valid;
        logic [W-1:0] bd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   r;
        rst = 1'b1; req = '0; data = '0;
        d = {16'hD003, 16'hBEEF, 16'hD001, 16'hD000};
        m_owner = -1; m_last = N - 1; m_sel = 0; m_cnt = 0; m_bv = 1'b0; m_bd = '0;

        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'hBEEF};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'hBEEF};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'hBEEF};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 16'hBEEF};
        tbl[7]  = '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1, 16'hBEEF};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0000, 2'd2, 1'b0, 16'hBEEF};
        tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, 16'hBEEF};
        tbl[10] = '{1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[11] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, 16'h0000};

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].req, d);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d_valid", i), 32'(bus_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_bus_data", i), 32'(bus_data), 32'(tbl[i].bd));
        end

        // Rotation: every owner keeps the bus 3 cycles, then drops for one cycle.
        cycle(1'b1, 4'b1111, d);
        cycle(1'b0, 4'b1111, d);
        chk("rot_first_grant", 32'(grant), 32'h1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 4'b1111, d);
            cycle(1'b0, 4'b1111, d);
            chk($sformatf("rot%0d_held", k), 32'(grant), 32'd1 << k);
            chk($sformatf("rot%0d_data", k), 32'(bus_data), 32'(d[k*W +: W]));
            cycle(1'b0, 4'b1111 & ~(4'b0001 << k), d);
            chk($sformatf("rot%0d_dead_grant", k), 32'(grant), 32'h0);
            chk($sformatf("rot%0d_dead_valid", k), 32'(bus_valid), 32'h0);
            cycle(1'b0, 4'b1111, d);
            chk($sformatf("rot%0d_next", k), 32'(grant), 32'd1 << ((k + 1) % 4));
        end

        // Two contending requesters held high: preemption only with the timeout build.
        cycle(1'b1, 4'b0000, d);
        for (int i = 1; i <= 12; i++) begin
            logic [N-1:0] eg;
            logic         ep;
            cycle(1'b0, 4'b0011, d);
            if (!TMO || i <= 8) eg = 4'b0001;
            else if (i == 9)    eg = 4'b0000;
            else                eg = 4'b0010;
            ep = TMO && (i == 8);
            chk($sformatf("tmo%0d_grant", i), 32'(grant), 32'(eg));
            chk($sformatf("tmo%0d_preempt", i), 32'(preempt), 32'(ep));
        end

        // Random traffic with sticky requests so long ownerships occur.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle($urandom_range(0, 63) == 0, r, {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
